// File: rtl/scoreboarded_register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboarded_register_file_if
//  Description : Bus bundle between decode/issue + writeback (master) and the
//                scoreboarded register file (slave).
//                  rd_addr/rd_data/rd_ready  : NUM_READ packed read ports
//                  rsv_valid/rsv_addr/rsv_tag: destination reservation
//                  wb_valid/wb_addr/wb_tag/wb_data/wb_dropped : writeback
//  Revision    : 1.0 - initial release
// ============================================================================
interface scoreboarded_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int TAG_WIDTH  = 3
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_READ*AW-1:0]         rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ-1:0]            rd_ready;

    logic                           rsv_valid;
    logic [AW-1:0]                  rsv_addr;
    logic [TAG_WIDTH-1:0]           rsv_tag;

    logic                           wb_valid;
    logic [AW-1:0]                  wb_addr;
    logic [TAG_WIDTH-1:0]           wb_tag;
    logic [DATA_WIDTH-1:0]          wb_data;
    logic                           wb_dropped;

    modport master (
        output rd_addr, rsv_valid, rsv_addr, wb_valid, wb_addr, wb_tag, wb_data,
        input  rd_data, rd_ready, rsv_tag, wb_dropped
    );

    modport slave (
        input  rd_addr, rsv_valid, rsv_addr, wb_valid, wb_addr, wb_tag, wb_data,
        output rd_data, rd_ready, rsv_tag, wb_dropped
    );
endinterface
`default_nettype wire

// File: rtl/scoreboarded_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboarded_register_file
//  Description : Register file with per-register pending tracking. A
//                reservation marks a destination pending and records the
//                current producer tag; a writeback only retires the value if
//                its tag matches the newest producer. Reads are combinational
//                and bypass a same-cycle accepted writeback.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                bus (slave)- read ports, reservation and writeback channels
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboarded_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int TAG_WIDTH  = 3
) (
    input  wire                            clk,
    input  wire                            rst,
    scoreboarded_register_file_if.slave    bus
);

    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_data [NUM_REGS];
    logic [TAG_WIDTH-1:0]  r_ptag [NUM_REGS];
    logic [NUM_REGS-1:0]   r_pending;
    logic [TAG_WIDTH-1:0]  r_tcnt;
    logic                  r_wb_dropped;

    logic                  w_rsv_acc;
    logic                  w_wb_nonzero;
    logic                  w_wb_acc;
    logic                  w_wb_rej;

    // Register 0 is hardwired: never reserved, never written, so its data
    // stays 0 and its pending bit stays 0 without any special read logic.
    assign w_rsv_acc    = bus.rsv_valid && (bus.rsv_addr != '0);
    assign w_wb_nonzero = bus.wb_valid  && (bus.wb_addr  != '0);
    assign w_wb_acc     = w_wb_nonzero && r_pending[bus.wb_addr]
                          && (r_ptag[bus.wb_addr] == bus.wb_tag);
    assign w_wb_rej     = w_wb_nonzero && !w_wb_acc;

    assign bus.rsv_tag    = r_tcnt;
    assign bus.wb_dropped = r_wb_dropped;

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd_port
            logic [AW-1:0] w_addr;
            logic          w_bypass;

            assign w_addr   = bus.rd_addr[gi*AW +: AW];
            assign w_bypass = w_wb_acc && (bus.wb_addr == w_addr);

            assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                w_bypass ? bus.wb_data : r_data[w_addr];
            assign bus.rd_ready[gi] = w_bypass || !r_pending[w_addr];
        end
    endgenerate

    // The reservation update follows the writeback update so that a
    // same-cycle writeback and reservation to one register leaves it
    // pending under the new tag while still capturing the written data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_data[i] <= '0;
                r_ptag[i] <= '0;
            end
            r_pending    <= '0;
            r_tcnt       <= '0;
            r_wb_dropped <= 1'b0;
        end else begin
            if (w_wb_acc) begin
                r_data[bus.wb_addr]    <= bus.wb_data;
                r_pending[bus.wb_addr] <= 1'b0;
            end
            if (w_rsv_acc) begin
                r_pending[bus.rsv_addr] <= 1'b1;
                r_ptag[bus.rsv_addr]    <= r_tcnt;
                r_tcnt                  <= r_tcnt + TAG_WIDTH'(1);
            end
            r_wb_dropped <= w_wb_rej;
        end
    end

endmodule
`default_nettype wire
